// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg
//   Shared constants and helpers for the raster timing generator.
//   - DEF_* : the 320x480 mode on a 12.5875 MHz pixel clock (400x525 raster)
//   - mode_t presets: MODE_320X480 (default) and MODE_256X240 (no y scaling)
//   - axisTotal(): full length of one axis (visible + porches + sync)
package video_timing_pkg;

  localparam int DEF_H_VISIBLE = 320;
  localparam int DEF_H_FRONT   = 8;
  localparam int DEF_H_SYNC    = 48;
  localparam int DEF_H_BACK    = 24;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_X_SHIFT   = 0;
  localparam int DEF_Y_SHIFT   = 1;

  typedef struct packed {
    int hVisible;
    int hFront;
    int hSync;
    int hBack;
    int vVisible;
    int vFront;
    int vSync;
    int vBack;
    int xShift;
    int yShift;
  } mode_t;

  localparam mode_t MODE_320X480 = '{
    hVisible: DEF_H_VISIBLE, hFront: DEF_H_FRONT, hSync: DEF_H_SYNC, hBack: DEF_H_BACK,
    vVisible: DEF_V_VISIBLE, vFront: DEF_V_FRONT, vSync: DEF_V_SYNC, vBack: DEF_V_BACK,
    xShift: DEF_X_SHIFT, yShift: DEF_Y_SHIFT
  };

  // 256x240 on a 336x262 raster, one line per row so no vertical scaling.
  localparam mode_t MODE_256X240 = '{
    hVisible: 256, hFront: 8, hSync: 32, hBack: 40,
    vVisible: 240, vFront: 3, vSync: 3, vBack: 16,
    xShift: 0, yShift: 0
  };

  function automatic int axisTotal(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
//   Bundle between the timing generator and its consumers (pixel pipeline,
//   PPU/CPU arbitration).
//   - en            : pixel advance enable, driven by the consumer side
//   - hsync/vsync   : sync levels, polarity fixed by the generator parameters
//   - visible/xp/yp : visibility and scaled coordinates of the current pixel
//   - writable      : vertical blanking, VRAM/OAM free for the CPU
//   - line_start/frame_start/vblank_start : single-clk event pulses
//   - frame_count   : completed-frame counter
//   Modports: master = generator, slave = consumer.
interface video_timing_gen_if #(
  parameter int XP_W    = 8,
  parameter int YP_W    = 8,
  parameter int FRAME_W = 8
) ();

  logic               en;
  logic               hsync;
  logic               vsync;
  logic               visible;
  logic [XP_W-1:0]    xp;
  logic [YP_W-1:0]    yp;
  logic               writable;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  en,
    output hsync, vsync, visible, xp, yp, writable,
           line_start, frame_start, vblank_start, frame_count
  );

  modport slave (
    output en,
    input  hsync, vsync, visible, xp, yp, writable,
           line_start, frame_start, vblank_start, frame_count
  );

endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// video_axis_counter
//   One raster axis: a position counter that wraps after VISIBLE+FRONT+SYNC+BACK
//   steps and restarts from its last position on reset.
//   Ports:
//   - clk, rst     : clock, synchronous active-high reset
//   - step_i       : advance one position on this edge
//   - count_o      : position the counter holds after this edge
//   - wrap_o       : this edge moves the counter from its last position to 0
//   - in_visible_o : count_o lies in the visible region
//   - in_sync_o    : count_o lies in the sync region
//   All outputs look ahead to the position being entered so that the parent
//   can register its decoded outputs on the same edge as the position itself.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int VISIBLE = 320,
  parameter int FRONT   = 8,
  parameter int SYNC    = 48,
  parameter int BACK    = 24,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         in_visible_o,
  output logic         in_sync_o
);

  localparam int TOTAL = axisTotal(VISIBLE, FRONT, SYNC, BACK);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END    = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_BEGIN = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] SYNC_END   = W'(VISIBLE + FRONT + SYNC);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         atLast;

  assign atLast = (count_q == LAST);

  // Next position: hold unless stepped, wrap to 0 after the last position.
  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = atLast ? '0 : count_q + 1'b1;
    end
  end

  // Reset parks the axis on its last position so the first step enters 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_d;
  assign wrap_o       = step_i & atLast;
  assign in_visible_o = (count_d < VIS_END);
  assign in_sync_o    = (count_d >= SYNC_BEGIN) && (count_d < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator: sync, visibility, scaled pixel
//   coordinates, CPU-writable window, line/frame/vblank event pulses and a
//   completed-frame counter.
//   Ports:
//   - clk : pixel or system clock
//   - rst : synchronous, active-high reset
//   - vif : video_timing_gen_if.master (en in; all timing outputs out)
//   Every output is a register loaded on the same edge as the position, so it
//   always describes the current (hcount, vcount).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int X_SHIFT   = DEF_X_SHIFT,
  parameter int Y_SHIFT   = DEF_Y_SHIFT,
  parameter int CNT_W     = 10,
  parameter int XP_W      = 8,
  parameter int YP_W      = 8,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = axisTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axisTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Zero-length porches or sync would collapse the decode windows, and a
  // narrow counter could never reach the end of the line or frame.
  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : gBadGeometry
    $error("video_timing_gen: porch, sync and visible lengths must be non-zero");
  end
  if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : gBadCounterWidth
    $error("video_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] hNext;
  logic [CNT_W-1:0] vNext;
  logic             hWrap;
  logic             vWrap;
  logic             hInVis;
  logic             vInVis;
  logic             hInSync;
  logic             vInSync;
  logic             vStep;

  // The vertical axis moves only on the edge that wraps the horizontal one.
  assign vStep = vif.en & hWrap;

  video_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .W       (CNT_W)
  ) uHAxis (
    .clk          (clk),
    .rst          (rst),
    .step_i       (vif.en),
    .count_o      (hNext),
    .wrap_o       (hWrap),
    .in_visible_o (hInVis),
    .in_sync_o    (hInSync)
  );

  video_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .W       (CNT_W)
  ) uVAxis (
    .clk          (clk),
    .rst          (rst),
    .step_i       (vStep),
    .count_o      (vNext),
    .wrap_o       (vWrap),
    .in_visible_o (vInVis),
    .in_sync_o    (vInSync)
  );

  logic               hsync_q,       hsync_d;
  logic               vsync_q,       vsync_d;
  logic               visible_q,     visible_d;
  logic [XP_W-1:0]    xp_q,          xp_d;
  logic [YP_W-1:0]    yp_q,          yp_d;
  logic               writable_q,    writable_d;
  logic               lineStart_q,   lineStart_d;
  logic               frameStart_q,  frameStart_d;
  logic               vblankStart_q, vblankStart_d;
  logic [FRAME_W-1:0] frameCount_q,  frameCount_d;

  // Decode the position being entered; coordinates are zeroed outside the
  // visible area so consumers never see porch or sync addresses.
  always_comb begin
    visible_d     = hInVis & vInVis;
    hsync_d       = hInSync ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = vInSync ? VSYNC_POL : ~VSYNC_POL;
    xp_d          = visible_d ? XP_W'(hNext >> X_SHIFT) : '0;
    yp_d          = visible_d ? YP_W'(vNext >> Y_SHIFT) : '0;
    writable_d    = ~vInVis;
    lineStart_d   = hWrap;
    frameStart_d  = hWrap & vWrap;
    vblankStart_d = hWrap & (vNext == CNT_W'(V_VISIBLE));
    frameCount_d  = frameStart_d ? frameCount_q + 1'b1 : frameCount_q;
  end

  // Reset wins over en; with en low the levels hold and the pulses drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      visible_q     <= 1'b0;
      xp_q          <= '0;
      yp_q          <= '0;
      writable_q    <= 1'b1;
      lineStart_q   <= 1'b0;
      frameStart_q  <= 1'b0;
      vblankStart_q <= 1'b0;
      frameCount_q  <= '0;
    end else if (vif.en) begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      xp_q          <= xp_d;
      yp_q          <= yp_d;
      writable_q    <= writable_d;
      lineStart_q   <= lineStart_d;
      frameStart_q  <= frameStart_d;
      vblankStart_q <= vblankStart_d;
      frameCount_q  <= frameCount_d;
    end else begin
      lineStart_q   <= 1'b0;
      frameStart_q  <= 1'b0;
      vblankStart_q <= 1'b0;
    end
  end

  assign vif.hsync        = hsync_q;
  assign vif.vsync        = vsync_q;
  assign vif.visible      = visible_q;
  assign vif.xp           = xp_q;
  assign vif.yp           = yp_q;
  assign vif.writable     = writable_q;
  assign vif.line_start   = lineStart_q;
  assign vif.frame_start  = frameStart_q;
  assign vif.vblank_start = vblankStart_q;
  assign vif.frame_count  = frameCount_q;

`ifdef SIM
  // Simulation-only progress marker at the start of each frame.
  always @(posedge clk) begin
    if (frameStart_q) begin
      $display("[video_timing_gen] next frame, frame_count=%0d", frameCount_q);
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Directed bench for video_timing_gen with three instances:
//   - dutD : default 400x525 geometry (line scan, mid-frame reset)
//   - dutT : 14-pixel lines with the default 525-line frame (vertical events)
//   - dutS : 14x7 raster, active-low syncs (en gating, reset mid-frame)
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rstD, rstT, rstS;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.XP_W(8), .YP_W(8), .FRAME_W(8)) ifD ();
  video_timing_gen_if #(.XP_W(8), .YP_W(8), .FRAME_W(8)) ifT ();
  video_timing_gen_if #(.XP_W(8), .YP_W(8), .FRAME_W(8)) ifS ();

  video_timing_gen dutD (
    .clk (clk),
    .rst (rstD),
    .vif (ifD)
  );

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .Y_SHIFT(1)
  ) dutT (
    .clk (clk),
    .rst (rstT),
    .vif (ifT)
  );

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .X_SHIFT(0), .Y_SHIFT(0), .CNT_W(4)
  ) dutS (
    .clk (clk),
    .rst (rstS),
    .vif (ifS)
  );

  // Advance n clocks; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input int cyc,
                             input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, observed, expected);
    end
  endtask

  initial begin
    int h, v, p, n, eh, ev;
    logic en;

    rstD = 1'b1; rstT = 1'b1; rstS = 1'b1;
    ifD.en = 1'b0; ifT.en = 1'b0; ifS.en = 1'b0;
    applyStimulus(2);
    rstD = 1'b0; rstT = 1'b0; rstS = 1'b0;

    // Reset state.
    checkOutput("rst_hsync",    0, ifD.hsync, 0);
    checkOutput("rst_vsync",    0, ifD.vsync, 0);
    checkOutput("rst_visible",  0, ifD.visible, 0);
    checkOutput("rst_xp",       0, ifD.xp, 0);
    checkOutput("rst_yp",       0, ifD.yp, 0);
    checkOutput("rst_writable", 0, ifD.writable, 1);
    checkOutput("rst_line",     0, ifD.line_start, 0);
    checkOutput("rst_frame",    0, ifD.frame_start, 0);
    checkOutput("rst_vblank",   0, ifD.vblank_start, 0);
    checkOutput("rst_fcount",   0, ifD.frame_count, 0);
    checkOutput("rstS_hsync",   0, ifS.hsync, 1);
    checkOutput("rstS_vsync",   0, ifS.vsync, 1);

    // Line 0 scan on the default geometry.
    ifD.en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1);
      checkOutput("d_visible", c, ifD.visible, (c < 320) ? 1 : 0);
      checkOutput("d_hsync",   c, ifD.hsync, (c >= 328 && c <= 375) ? 1 : 0);
      checkOutput("d_xp",      c, ifD.xp, (c < 320) ? (c % 256) : 0);
      checkOutput("d_yp",      c, ifD.yp, 0);
      checkOutput("d_line",    c, ifD.line_start, (c == 0) ? 1 : 0);
      checkOutput("d_frame",   c, ifD.frame_start, (c == 0) ? 1 : 0);
      checkOutput("d_fcount",  c, ifD.frame_count, 1);
      checkOutput("d_writable", c, ifD.writable, 0);
      checkOutput("d_vsync",   c, ifD.vsync, 0);
    end
    applyStimulus(1);
    checkOutput("d_line1_start", 400, ifD.line_start, 1);
    checkOutput("d_line1_frame", 400, ifD.frame_start, 0);
    applyStimulus(123);
    checkOutput("d_xp_123",  523, ifD.xp, 123);
    checkOutput("d_yp_l1",   523, ifD.yp, 0);

    // Reset at (123, 1) while en is high.
    rstD = 1'b1;
    applyStimulus(1);
    checkOutput("mrst_visible",  0, ifD.visible, 0);
    checkOutput("mrst_xp",       0, ifD.xp, 0);
    checkOutput("mrst_writable", 0, ifD.writable, 1);
    checkOutput("mrst_fcount",   0, ifD.frame_count, 0);
    checkOutput("mrst_frame",    0, ifD.frame_start, 0);
    checkOutput("mrst_line",     0, ifD.line_start, 0);
    checkOutput("mrst_hsync",    0, ifD.hsync, 0);
    rstD = 1'b0; ifD.en = 1'b0;
    applyStimulus(1);
    checkOutput("mrst_hold_frame", 1, ifD.frame_start, 0);
    checkOutput("mrst_hold_vis",   1, ifD.visible, 0);
    ifD.en = 1'b1;
    applyStimulus(1);
    checkOutput("mrst_first_frame", 2, ifD.frame_start, 1);
    checkOutput("mrst_first_line",  2, ifD.line_start, 1);
    checkOutput("mrst_first_fc",    2, ifD.frame_count, 1);
    checkOutput("mrst_first_vis",   2, ifD.visible, 1);
    ifD.en = 1'b0;
    applyStimulus(1);
    checkOutput("d_en0_frame", 3, ifD.frame_start, 0);
    checkOutput("d_en0_line",  3, ifD.line_start, 0);
    checkOutput("d_en0_vis",   3, ifD.visible, 1);

    // Full frame plus one pixel on 14-pixel lines and 525 lines.
    ifT.en = 1'b1;
    for (int k = 1; k <= 7351; k++) begin
      applyStimulus(1);
      p = (k - 1) % 7350;
      h = p % 14;
      v = p / 14;
      checkOutput("t_frame",    k, ifT.frame_start, (p == 0) ? 1 : 0);
      checkOutput("t_line",     k, ifT.line_start, (h == 0) ? 1 : 0);
      checkOutput("t_vblank",   k, ifT.vblank_start, (h == 0 && v == 480) ? 1 : 0);
      checkOutput("t_writable", k, ifT.writable, (v >= 480) ? 1 : 0);
      checkOutput("t_vsync",    k, ifT.vsync, (v == 490 || v == 491) ? 1 : 0);
      checkOutput("t_visible",  k, ifT.visible, (h < 8 && v < 480) ? 1 : 0);
      checkOutput("t_yp",       k, ifT.yp, (h < 8 && v < 480) ? (v / 2) : 0);
      checkOutput("t_fcount",   k, ifT.frame_count, ((k - 1) / 7350) + 1);
      if (h == 0 && v == 479) checkOutput("t_yp_479", k, ifT.yp, 239);
      if (h == 0 && v == 480) checkOutput("t_yp_480", k, ifT.yp, 0);
    end
    checkOutput("t_fcount_end", 7351, ifT.frame_count, 2);
    ifT.en = 1'b0;

    // Small raster with en toggling every other cycle.
    n = 0;
    for (int i = 0; i < 200; i++) begin
      en = (i % 2 == 0);
      ifS.en = en;
      applyStimulus(1);
      if (en) n++;
      p = (n - 1) % 98;
      eh = p % 14;
      ev = p / 14;
      checkOutput("s_hsync",   i, ifS.hsync, (eh == 10 || eh == 11) ? 0 : 1);
      checkOutput("s_vsync",   i, ifS.vsync, (ev == 5) ? 0 : 1);
      checkOutput("s_visible", i, ifS.visible, (eh < 8 && ev < 4) ? 1 : 0);
      checkOutput("s_xp",      i, ifS.xp, (eh < 8 && ev < 4) ? eh : 0);
      checkOutput("s_yp",      i, ifS.yp, (eh < 8 && ev < 4) ? ev : 0);
      checkOutput("s_writable", i, ifS.writable, (ev >= 4) ? 1 : 0);
      checkOutput("s_frame",   i, ifS.frame_start, (en && p == 0) ? 1 : 0);
      checkOutput("s_line",    i, ifS.line_start, (en && eh == 0) ? 1 : 0);
      checkOutput("s_vblank",  i, ifS.vblank_start, (en && eh == 0 && ev == 4) ? 1 : 0);
      checkOutput("s_fcount",  i, ifS.frame_count, ((n - 1) / 98) + 1);
    end

    // Reset mid-frame on the small raster with en high.
    rstS = 1'b1; ifS.en = 1'b1;
    applyStimulus(1);
    checkOutput("srst_hsync",    0, ifS.hsync, 1);
    checkOutput("srst_vsync",    0, ifS.vsync, 1);
    checkOutput("srst_visible",  0, ifS.visible, 0);
    checkOutput("srst_xp",       0, ifS.xp, 0);
    checkOutput("srst_writable", 0, ifS.writable, 1);
    checkOutput("srst_fcount",   0, ifS.frame_count, 0);
    checkOutput("srst_frame",    0, ifS.frame_start, 0);
    rstS = 1'b0;
    applyStimulus(1);
    checkOutput("srst_first_frame", 1, ifS.frame_start, 1);
    checkOutput("srst_first_fc",    1, ifS.frame_count, 1);
    checkOutput("srst_first_vis",   1, ifS.visible, 1);
    ifS.en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
